op_collector: RTL and testbench

Registered, parametrised operand collector for the PE datapath. It selects NUM_OPS operands from NUM_SRC valid-tagged sources: zero, ALU feedback, weight, data, meta, interim, neighbour and bus in the default build. Unlike a plain combinational operand mux, it waits until every selected source is valid, captures each operand as it arrives, and pops each consumed source exactly once. It then presents the full operand set to the ALU under a valid/ready handshake.

---
 rtl/op_collector_if.sv | 34 +++
 rtl/op_collector.sv | 115 +++++++++++
 tb/tb_op_collector.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/op_collector_if.sv
// Operand collector handshake bundle: selector in, sources in/pop out,
// operand set out to the ALU.
interface op_collector_if #(
  parameter int LEN     = 16,
  parameter int NUM_SRC = 8,
  parameter int NUM_OPS = 3,
  parameter int SEL_W   = $clog2(NUM_SRC)
);
  logic                     inst_valid;
  logic                     inst_ready;
  logic [NUM_OPS*SEL_W-1:0] inst_sel;
  logic [NUM_SRC*LEN-1:0]   src_data;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_pop;
  logic [NUM_OPS*LEN-1:0]   op_data;
  logic                     op_valid;
  logic                     op_ready;

  modport master (
    output inst_valid, inst_sel,
    output src_data, src_valid,
    output op_ready,
    input  inst_ready, src_pop,
    input  op_data, op_valid
  );

  modport slave (
    input  inst_valid, inst_sel,
    input  src_data, src_valid,
    input  op_ready,
    output inst_ready, src_pop,
    output op_data, op_valid
  );
endinterface

// File: rtl/op_collector.sv
// Registered operand collector: waits for every selected source,
// captures each once, pops each consumed source once, hands set to ALU.
module op_collector #(
  parameter int LEN     = 16,
  parameter int NUM_SRC = 8,
  parameter int NUM_OPS = 3,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  op_collector_if.slave      bus,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [NUM_OPS*SEL_W-1:0] sel_q, sel_d;
  logic [NUM_OPS-1:0]       cap_q, cap_d;
  logic [NUM_OPS*LEN-1:0]   op_q, op_d;
  logic                     op_valid_q, op_valid_d;
  logic [STALL_W-1:0]       stall_q, stall_d;
  logic [NUM_SRC-1:0]       pop;
  logic [SEL_W-1:0]         s;
  logic                     accept;
  logic                     unused_ok;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cap_d      = cap_q;
    op_d       = op_q;
    op_valid_d = op_valid_q;
    stall_d    = stall_q;
    pop        = '0;
    s          = '0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: accept = bus.inst_valid;
      COLLECT: begin
        for (int k = 0; k < NUM_OPS; k++) begin
          s = sel_q[k*SEL_W +: SEL_W];
          if (!cap_q[k]) begin
            if (s == '0 || int'(s) >= NUM_SRC) begin
              op_d[k*LEN +: LEN] = '0;
              cap_d[k]           = 1'b1;
            end else begin
              // shared sources: every slot grabs the same value, one pop
              for (int j = 1; j < NUM_SRC; j++) begin
                if (int'(s) == j && bus.src_valid[j]) begin
                  op_d[k*LEN +: LEN] = bus.src_data[j*LEN +: LEN];
                  cap_d[k]           = 1'b1;
                  pop[j]             = 1'b1;
                end
              end
            end
          end
        end
        if (&cap_d) begin
          state_d    = DONE;
          op_valid_d = 1'b1;
        end else if (stall_q != '1) begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      DONE: begin
        if (bus.op_ready) begin
          op_valid_d = 1'b0;
          state_d    = IDLE;
          accept     = bus.inst_valid;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = COLLECT;
      sel_d   = bus.inst_sel;
      cap_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      cap_q      <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cap_q      <= cap_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.src_pop    = reset ? '0 : pop;
  assign bus.inst_ready = (state_q == IDLE) ||
                          (state_q == DONE && bus.op_ready);
  assign bus.op_valid   = op_valid_q;
  assign bus.op_data    = op_q;
  assign stall_cnt      = stall_q;

  // channel 0 is the hard-wired zero and never read
  assign unused_ok = ^{bus.src_valid[0], bus.src_data[LEN-1:0]};

endmodule

// File: tb/tb_op_collector.sv
// Scoreboard bench for op_collector: directed timing cases plus
// randomized traffic against a per-source consumption model.
module tb_op_collector;
  localparam int LEN = 16;
  localparam int NS  = 8;
  localparam int NO  = 3;
  localparam int SW  = 3;
  localparam int NV  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] stall;
  logic [3:0]  stall4;

  always #5 clk = ~clk;

  op_collector_if #(.LEN(LEN), .NUM_SRC(NS), .NUM_OPS(NO), .SEL_W(SW)) b ();
  op_collector_if #(.LEN(LEN), .NUM_SRC(NS), .NUM_OPS(NO), .SEL_W(SW)) b4 ();

  op_collector #(
    .LEN(LEN), .NUM_SRC(NS), .NUM_OPS(NO), .SEL_W(SW), .STALL_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(b), .stall_cnt(stall)
  );

  op_collector #(
    .LEN(LEN), .NUM_SRC(NS), .NUM_OPS(NO), .SEL_W(SW), .STALL_W(4)
  ) dut4 (
    .clk(clk), .reset(reset), .bus(b4), .stall_cnt(stall4)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [NO*LEN-1:0] exp_q[$];
  logic [15:0] vals[NS][NV];
  int idx[NS];
  int cnt[NS];
  bit auto_en = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NO*SW-1:0] sel3(int a, int c1, int c2);
    return {SW'(c2), SW'(c1), SW'(a)};
  endfunction

  function automatic logic [NO*LEN-1:0] pk(int a, int c1, int c2);
    return {LEN'(c2), LEN'(c1), LEN'(a)};
  endfunction

  task automatic setsrc(int j, logic [15:0] v);
    b.src_data[j*LEN +: LEN] = v;
    b.src_valid[j] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    b.inst_valid = 1'b0;
    b.inst_sel = '0;
    b.src_valid = '0;
    b.src_data = '0;
    b.op_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // monitor: pop legality every cycle, operand sets against scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (b.src_pop != '0)
        chk("pop_legal", b.src_pop & ~{b.src_valid[NS-1:1], 1'b0}, 0);
      if (b.op_valid && b.op_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("op_data", b.op_data, exp_q.pop_front());
      end
    end
  end

  // randomized source model: each source streams vals[j][] in order
  initial begin
    logic [NS-1:0] p;
    forever begin
      @(negedge clk);
      p = b.src_pop;
      @(posedge clk);
      #1;
      if (auto_en) begin
        for (int j = 1; j < NS; j++) begin
          if (p[j]) idx[j]++;
          b.src_valid[j] = (idx[j] < NV) && ($urandom_range(0, 99) < 60);
          b.src_data[j*LEN +: LEN] = (idx[j] < NV) ? vals[j][idx[j]] : '0;
        end
        b.src_valid[0] = 1'($urandom);
        b.src_data[0 +: LEN] = 16'($urandom);
        b.op_ready = ($urandom_range(0, 99) < 70);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int st_t[3];
    int st_s[3];
    logic [NS-1:0] m;
    for (int j = 0; j < NS; j++) begin
      idx[j] = 0;
      cnt[j] = 0;
      for (int i = 0; i < NV; i++) vals[j][i] = 16'($urandom);
    end
    b4.inst_valid = 1'b0;
    b4.inst_sel = '0;
    b4.src_valid = '0;
    b4.src_data = '0;
    b4.op_ready = 1'b1;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_inst_ready", b.inst_ready, 1);
    chk("rst_op_valid", b.op_valid, 0);
    chk("rst_pop", b.src_pop, 0);
    chk("rst_stall", stall, 0);
    chk("rst_op_data", b.op_data, 0);

    // simple set
    step();
    b.inst_sel = sel3(2, 3, 1);
    b.inst_valid = 1'b1;
    @(negedge clk);
    chk("simple_accept", b.inst_ready, 1);
    step();
    b.inst_valid = 1'b0;
    setsrc(2, 16'h0011);
    setsrc(3, 16'h0022);
    setsrc(1, 16'h0033);
    exp_q.push_back(pk('h11, 'h22, 'h33));
    @(negedge clk);
    chk("simple_pop", b.src_pop, 8'b0000_1110);
    chk("simple_early", b.op_valid, 0);
    step();
    b.src_valid = '0;
    @(negedge clk);
    chk("simple_valid", b.op_valid, 1);
    step();

    // staggered arrival
    do_reset();
    b.inst_sel = sel3(6, 7, 4);
    b.inst_valid = 1'b1;
    st_t = '{1, 3, 5};
    st_s = '{6, 7, 4};
    exp_q.push_back(pk('h0606, 'h0707, 'h0404));
    for (int t = 1; t <= 5; t++) begin
      step();
      b.inst_valid = 1'b0;
      b.src_valid = '0;
      m = '0;
      for (int i = 0; i < 3; i++)
        if (st_t[i] == t) begin
          setsrc(st_s[i], 16'(st_s[i] * 'h0101));
          m[st_s[i]] = 1'b1;
        end
      @(negedge clk);
      chk("stag_pop", b.src_pop, m);
      chk("stag_not_valid", b.op_valid, 0);
    end
    step();
    b.src_valid = '0;
    @(negedge clk);
    chk("stag_valid", b.op_valid, 1);
    chk("stag_stall", stall, 4);
    step();

    // shared source
    do_reset();
    b.inst_sel = sel3(3, 3, 0);
    b.inst_valid = 1'b1;
    step();
    b.inst_valid = 1'b0;
    setsrc(3, 16'hBEEF);
    exp_q.push_back(pk('hBEEF, 'hBEEF, 0));
    @(negedge clk);
    chk("shared_pop", b.src_pop, 8'b0000_1000);
    step();
    @(negedge clk);
    chk("shared_no_repop", b.src_pop, 0);
    chk("shared_valid", b.op_valid, 1);
    step();

    // backpressure then back-to-back all-zero selector
    do_reset();
    b.op_ready = 1'b0;
    b.inst_sel = sel3(1, 1, 1);
    b.inst_valid = 1'b1;
    step();
    b.inst_valid = 1'b0;
    setsrc(1, 16'h1234);
    exp_q.push_back(pk('h1234, 'h1234, 'h1234));
    step();
    setsrc(1, 16'h9999);
    b.inst_sel = '0;
    b.inst_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", b.op_valid, 1);
      chk("bp_ready", b.inst_ready, 0);
      chk("bp_pop", b.src_pop, 0);
      chk("bp_data", b.op_data, pk('h1234, 'h1234, 'h1234));
      step();
    end
    b.op_ready = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    chk("bp_accept", b.inst_ready, 1);
    step();
    b.inst_valid = 1'b0;
    @(negedge clk);
    chk("zero_pop", b.src_pop, 0);
    chk("zero_early", b.op_valid, 0);
    step();
    @(negedge clk);
    chk("zero_valid", b.op_valid, 1);
    chk("zero_stall", stall, 0);
    step();

    // reset mid-collect with one slot captured
    do_reset();
    b.inst_sel = sel3(1, 5, 6);
    b.inst_valid = 1'b1;
    step();
    b.inst_valid = 1'b0;
    setsrc(1, 16'h0101);
    @(negedge clk);
    chk("rmc_pop1", b.src_pop, 8'b0000_0010);
    step();
    b.src_valid = '0;
    setsrc(5, 16'h0505);
    setsrc(6, 16'h0606);
    reset = 1'b1;
    @(negedge clk);
    chk("rmc_pop_in_reset", b.src_pop, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rmc_ready", b.inst_ready, 1);
    chk("rmc_valid", b.op_valid, 0);
    chk("rmc_stall", stall, 0);
    chk("rmc_data", b.op_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rmc_pop_after", b.src_pop, 0);
      step();
    end

    // stall counter saturation on the narrow instance
    do_reset();
    b4.inst_sel = sel3(7, 0, 0);
    b4.inst_valid = 1'b1;
    step();
    b4.inst_valid = 1'b0;
    repeat (20) step();
    @(negedge clk);
    chk("sat_cnt", stall4, 4'hF);
    repeat (3) step();
    @(negedge clk);
    chk("sat_hold", stall4, 4'hF);
    chk("sat_no_valid", b4.op_valid, 0);
    chk("sat_no_pop", b4.src_pop, 0);

    // randomized traffic
    chk("pre_random_empty", exp_q.size(), 0);
    do_reset();
    auto_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [NO*SW-1:0] sl;
      logic [NO*LEN-1:0] e;
      bit used[NS];
      bit acc;
      int w;
      int s;
      for (int k = 0; k < NO; k++)
        sl[k*SW +: SW] = SW'($urandom_range(0, NS - 1));
      b.inst_sel = sl;
      b.inst_valid = 1'b1;
      acc = 1'b0;
      w = 0;
      while (!acc && w < 300) begin
        @(negedge clk);
        acc = b.inst_ready;
        w++;
        if (acc) begin
          e = '0;
          used = '{default: 1'b0};
          for (int k = 0; k < NO; k++) begin
            s = int'(sl[k*SW +: SW]);
            if (s != 0) begin
              e[k*LEN +: LEN] = vals[s][cnt[s]];
              used[s] = 1'b1;
            end
          end
          for (int j = 0; j < NS; j++) if (used[j]) cnt[j]++;
          exp_q.push_back(e);
        end
        step();
      end
      if (!acc) begin
        chk("issue_timeout", 0, 1);
        break;
      end
      b.inst_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) step();
    end
    b.inst_valid = 1'b0;
    begin
      int w = 0;
      while (exp_q.size() != 0 && w < 2000) begin
        step();
        w++;
      end
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) step();
    auto_en = 1'b0;
    for (int j = 1; j < NS; j++)
      chk("pop_count", idx[j], cnt[j]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
